// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared encodings and widths for the MIPS pipeline
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] pc_plus8;
    logic [REG_W-1:0]  wr_reg;
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic [1:0]        ld_size;
    logic              ld_unsigned;
  } mem_wb_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// load_align : little-endian lane select and sign/zero extension of load data
// Rev 1.0
// ============================================================================
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] load_word_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_unsigned_i,
  output logic [DATA_W-1:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = load_word_i[8*offset_i +: 8];
    // Halfword loads ignore the low address bit.
    half_lane = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    case (ld_size_i)
      LD_BYTE: result_o = {{24{byte_lane[7] & ~ld_unsigned_i}}, byte_lane};
      LD_HALF: result_o = {{16{half_lane[15] & ~ld_unsigned_i}}, half_lane};
      default: result_o = load_word_i;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// wb_stage : MEM/WB pipeline register and writeback datapath
// Rev 1.0
// ============================================================================
module wb_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_word,
  input  logic [DATA_W-1:0] mem_pc_plus8,
  input  logic [REG_W-1:0]  mem_wr_reg,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_wb_sel,
  input  logic [1:0]        mem_ld_size,
  input  logic              mem_ld_unsigned,
  output logic [DATA_W-1:0] wr_data,
  output logic [REG_W-1:0]  wr_reg,
  output logic              reg_write,
  output logic              wb_valid
);

  mem_wb_t           wb_q, wb_d;
  logic [DATA_W-1:0] load_data;

  always_comb begin
    wb_d = wb_q;
    // A flush only kills the slot; the payload is left as-is.
    if (flush) begin
      wb_d.valid = 1'b0;
    end else if (!stall) begin
      wb_d.valid       = mem_valid;
      wb_d.alu_result  = mem_alu_result;
      wb_d.load_word   = mem_load_word;
      wb_d.pc_plus8    = mem_pc_plus8;
      wb_d.wr_reg      = mem_wr_reg;
      wb_d.reg_write   = mem_reg_write;
      wb_d.wb_sel      = mem_wb_sel;
      wb_d.ld_size     = mem_ld_size;
      wb_d.ld_unsigned = mem_ld_unsigned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  load_align u_load_align (
    .load_word_i   (wb_q.load_word),
    .offset_i      (wb_q.alu_result[1:0]),
    .ld_size_i     (wb_q.ld_size),
    .ld_unsigned_i (wb_q.ld_unsigned),
    .result_o      (load_data)
  );

  always_comb begin
    case (wb_q.wb_sel)
      WB_LOAD: wr_data = load_data;
      WB_LINK: wr_data = wb_q.pc_plus8;
      default: wr_data = wb_q.alu_result;
    endcase
  end

  assign wr_reg    = wb_q.wr_reg;
  assign reg_write = wb_q.valid & wb_q.reg_write & (wb_q.wr_reg != '0);
  assign wb_valid  = wb_q.valid;

endmodule : wb_stage
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Pipeline MEM/WB register plus writeback datapath for the 5-stage MIPS core. Captures the memory-stage result at each rising clock edge, aligns and extends load data, selects the writeback source, and drives the register file write port (data, index, enable). The register file writes on the falling edge, so a value presented here is readable by ID in the same cycle.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and 5-bit register index.

Ports:
- clk  in  1  pipeline clock; state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold the current MEM/WB contents
- flush  in  1  invalidate the slot being captured (bubble)
- mem_valid  in  1  MEM stage holds a real instruction
- mem_alu_result  in  32  ALU result; also the load byte address
- mem_load_word  in  32  raw aligned word read from data memory
- mem_pc_plus8  in  32  link address for JAL/JALR
- mem_wr_reg  in  5  destination register index
- mem_reg_write  in  1  instruction writes a register
- mem_wb_sel  in  2  source: 00 ALU, 01 load, 10 link, 11 reserved (ALU)
- mem_ld_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (word)
- mem_ld_unsigned  in  1  zero-extend sub-word loads (LBU/LHU)
- wr_data  out  32  register file write data
- wr_reg  out  5  register file write index
- reg_write  out  1  register file write enable
- wb_valid  out  1  WB slot holds a real instruction (for hazard/forwarding)

## Operation
- Pipeline register fields: valid, alu_result, load_word, pc_plus8, wr_reg, reg_write, wb_sel, ld_size, ld_unsigned.
- Rising edge priority: flush > stall > capture.
  - flush: valid←0; all other fields keep their old value.
  - stall (no flush): all fields hold.
  - otherwise: all fields ← mem_* inputs; valid ← mem_valid.
- Load alignment (little-endian, offset = alu_result[1:0] of the registered fields):
  - byte: lane = load_word[8*offset +: 8]; sign-extend from bit 7 unless ld_unsigned.
  - halfword: lane = load_word[16*offset[1] +: 16]; offset[0] ignored; sign-extend from bit 15 unless ld_unsigned.
  - word/reserved: load_word unchanged; ld_unsigned ignored.
- wr_data = aligned load if wb_sel=01, pc_plus8 if 10, else alu_result.
- reg_write = valid & reg_write_q & (wr_reg ≠ 0). wr_reg = registered index, even when the enable is low.
- wb_valid = valid.

## Timing
- Latency: one cycle. mem_* sampled at rising edge N appear on outputs after edge N; register file commits at falling edge N+½.
- All outputs are combinational from the pipeline register only. There is no path from the mem_* inputs to the outputs.
- Reset (rst=0, async): all fields 0, so wr_data=0, wr_reg=0, reg_write=0, wb_valid=0 immediately, independent of clk. Outputs stay at those values until the first capture after rst rises.
- Reset mid-stall or mid-flush: reset wins; the held instruction is lost.
- stall held for k cycles: outputs constant for k cycles. reg_write stays asserted and rewrites the same value each falling edge. The rewrite is idempotent and allowed.
- flush and stall together: bubble inserted (flush wins).
- Back-to-back writes to the same register: each cycle's value is written in order; the last one wins.

## Structure
- Shared package `mips_pkg`: WB_ALU/WB_LOAD/WB_LINK encodings, LD_WORD/LD_HALF/LD_BYTE encodings, and the widths DATA_W=32 and REG_W=5. The control decoder imports the same package.
- One combinational sub-module `load_align` (load_word, offset, ld_size, ld_unsigned → 32-bit result). It is reused by any future MEM-stage forwarding.
- The top level holds the pipeline register and the writeback mux.

## Test plan
- Reset: assert rst low mid-cycle with valid captured data → reg_write=0, wr_data=0, wb_valid=0 before the next edge.
- Byte loads: load_word=0x80FF7F01; offset 0–3 signed → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned offset 3 → 0x00000080.
- Halfword loads: load_word=0x8001FFFE; offset 0 signed → 0xFFFFFFFE; offset 2 unsigned → 0x00008001; offset 3 → same as offset 2.
- Writeback select and r0: link with pc_plus8=0x00400010, wr_reg=31 → wr_data=0x00400010, reg_write=1. ALU write to wr_reg=0 → reg_write=0.
- Stall and flush: capture ALU 0x1234 to r5, then stall 3 cycles → outputs constant for 3 cycles. Then flush and stall together → wb_valid=0 and reg_write=0 next cycle.
- Invalid slot: mem_valid=0 with mem_reg_write=1 → reg_write=0 and the register file is unchanged.
